// File: rtl/pll_clk_seq_pkg.sv
// Shared types and constants for the PLL supervisor / clock-enable sequencer.
// Optional phase-align feature: PLL_CLK_SEQUENCER_PHASE_ALIGN_EN (see pll_clk_sequencer).
package pll_clk_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } seq_state_t;

  localparam int LOST_CNT_W = 8;

  // Increment giving an average enable rate of f_clk * num / den on an acc_w-bit accumulator.
  function automatic longint unsigned calc_inc(input int unsigned acc_w,
                                               input longint unsigned num,
                                               input longint unsigned den);
    return (num << acc_w) / den;
  endfunction

endpackage

// File: rtl/pll_clk_sequencer_ce_phase_acc.sv
// One fractional clock-enable channel: a phase accumulator whose carry-out is the enable.
// Built in all configurations; clear is tied low by the top when phase alignment is disabled.
module ce_phase_acc
  import pll_clk_seq_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Outside RUN, or on a sync clear, the phase restarts from zero with no enable emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (!run || clear) begin
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      acc <= sum[ACC_W-1:0];
      ce  <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/pll_clk_sequencer.sv
// PLL supervisor: relock sequencing, clean system reset release, lock-loss counting, fractional CEs.
// Optional macro PLL_CLK_SEQUENCER_PHASE_ALIGN_EN adds sync_in to phase-align all channels.
module pll_clk_sequencer
  import pll_clk_seq_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int ACC_W        = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pll_lock,
  output logic                    pll_reset,
  output logic                    rst_out,
  output logic                    locked,
  output logic [LOST_CNT_W-1:0]   lost_lock_count,
  input  logic [NUM_CH*ACC_W-1:0] ce_inc,
  output logic [NUM_CH-1:0]       ce_out
`ifdef PLL_CLK_SEQUENCER_PHASE_ALIGN_EN
  ,
  input  logic                    sync_in
`endif
);

  localparam logic [31:0] HOLD_LAST    = 32'(RST_HOLD - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  // The lock_s=1 cycle that moved us into STABLE already counts as the first stable cycle.
  localparam logic [31:0] STABLE_LAST  = (LOCK_STABLE >= 2) ? 32'(LOCK_STABLE - 2) : 32'd0;

  seq_state_t             state;
  logic [31:0]            cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   run_adv;
  logic                   ce_clear;

  // Lock is meaningless while the PLL is held in reset, so the synchroniser is flushed then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else if (state == PLL_RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= PLL_RST;
      cnt             <= '0;
      pll_reset       <= 1'b1;
      rst_out         <= 1'b1;
      locked          <= 1'b0;
      lost_lock_count <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == HOLD_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            rst_out   <= 1'b1;
            locked    <= 1'b0;
            if (lost_lock_count != '1) begin
              lost_lock_count <= lost_lock_count + 1'b1;
            end
          end else begin
            rst_out <= 1'b0;
            locked  <= 1'b1;
          end
        end
        default: begin
          state     <= PLL_RST;
          cnt       <= '0;
          pll_reset <= 1'b1;
          rst_out   <= 1'b1;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  // Accumulators stop on the very edge that leaves RUN, so no partial enable escapes.
  assign run_adv = (state == RUN) && lock_s;

`ifdef PLL_CLK_SEQUENCER_PHASE_ALIGN_EN
  assign ce_clear = sync_in;
`else
  assign ce_clear = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ce_phase_acc #(
      .ACC_W(ACC_W)
    ) u_acc (
      .clk  (clk),
      .reset(reset),
      .run  (run_adv),
      .clear(ce_clear),
      .inc  (ce_inc[k*ACC_W +: ACC_W]),
      .ce   (ce_out[k])
    );
  end

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Directed self-checking bench for pll_clk_sequencer (short LOCK_STABLE/LOCK_TIMEOUT for run time).
// Phase-align checks are compiled only with PLL_CLK_SEQUENCER_PHASE_ALIGN_EN defined.
module tb_pll_clk_sequencer;
  import pll_clk_seq_pkg::*;

  localparam int NUM_CH       = 2;
  localparam int ACC_W        = 24;
  localparam int SYNC_STAGES  = 2;
  localparam int RST_HOLD     = 16;
  localparam int LOCK_STABLE  = 64;
  localparam int LOCK_TIMEOUT = 256;
  localparam int T_RELEASE    = RST_HOLD + SYNC_STAGES + 1 + LOCK_STABLE;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    pll_lock = 1'b0;
  logic                    pll_reset;
  logic                    rst_out;
  logic                    locked;
  logic [LOST_CNT_W-1:0]   lost_lock_count;
  logic [NUM_CH*ACC_W-1:0] ce_inc = '0;
  logic [NUM_CH-1:0]       ce_out;
`ifdef PLL_CLK_SEQUENCER_PHASE_ALIGN_EN
  logic                    sync_in = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int ce1_count;

  pll_clk_sequencer #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_HOLD    (RST_HOLD),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .pll_reset      (pll_reset),
    .rst_out        (rst_out),
    .locked         (locked),
    .lost_lock_count(lost_lock_count),
    .ce_inc         (ce_inc),
    .ce_out         (ce_out)
`ifdef PLL_CLK_SEQUENCER_PHASE_ALIGN_EN
    ,
    .sync_in        (sync_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lock, input logic [ACC_W-1:0] inc0,
                               input logic [ACC_W-1:0] inc1);
    pll_lock = lock;
    ce_inc   = {inc1, inc0};
  endtask

  // After return, the next rising edge is edge 1 after reset release.
  task automatic resetDut();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic waitLocked(input string tag, input logic val, input int budget);
    int n = 0;
    while (locked !== val && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 64'(locked), 64'(val));
  endtask

  initial begin
    // Reset values, then retry cadence with pll_lock stuck low
    applyStimulus(1'b0, '0, '0);
    reset = 1'b1;
    tick(2);
    checkOutput("rst_pll_reset", 64'(pll_reset), 64'd1);
    checkOutput("rst_rst_out", 64'(rst_out), 64'd1);
    checkOutput("rst_locked", 64'(locked), 64'd0);
    checkOutput("rst_ce_out", 64'(ce_out), 64'd0);
    checkOutput("rst_lost", 64'(lost_lock_count), 64'd0);
    reset = 1'b0;
    tick(15);
    checkOutput("nolock_hold_e15", 64'(pll_reset), 64'd1);
    tick(1);
    checkOutput("nolock_hold_e16", 64'(pll_reset), 64'd0);
    tick(255);
    checkOutput("nolock_wait_e271", 64'(pll_reset), 64'd0);
    checkOutput("nolock_rst_e271", 64'(rst_out), 64'd1);
    tick(1);
    checkOutput("nolock_retry_e272", 64'(pll_reset), 64'd1);
    tick(15);
    checkOutput("nolock_retry_e287", 64'(pll_reset), 64'd1);
    tick(1);
    checkOutput("nolock_retry_e288", 64'(pll_reset), 64'd0);
    checkOutput("nolock_rst_e288", 64'(rst_out), 64'd1);
    checkOutput("nolock_locked_e288", 64'(locked), 64'd0);

    // Clean lock: release timing, then fractional enables
    applyStimulus(1'b1, 24'(1 << 22), 24'(calc_inc(ACC_W, 27, 192)));
    resetDut();
    tick(15);
    checkOutput("lock_hold_e15", 64'(pll_reset), 64'd1);
    tick(1);
    checkOutput("lock_hold_e16", 64'(pll_reset), 64'd0);
    tick(T_RELEASE - 1 - 16);
    checkOutput("lock_rst_before", 64'(rst_out), 64'd1);
    checkOutput("lock_locked_before", 64'(locked), 64'd0);
    checkOutput("lock_ce_before", 64'(ce_out), 64'd0);
    tick(1);
    checkOutput("lock_rst_release", 64'(rst_out), 64'd0);
    checkOutput("lock_locked_release", 64'(locked), 64'd1);

    // Samples here are RUN cycle k = edges after RUN entry
    ce1_count = 0;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) tick(1);
      checkOutput($sformatf("ce0_k%0d", k), 64'(ce_out[0]), 64'((k % 4) == 0));
      ce1_count += int'(ce_out[1]);
    end
    checkOutput("ce1_count_64", 64'(ce1_count), 64'd9);

    // inc0=0 never fires; all-ones fires every cycle after the first add
    applyStimulus(1'b1, '0, 24'hFF_FFFF);
    tick(5);
    checkOutput("ce0_zero_inc", 64'(ce_out[0]), 64'd0);
    checkOutput("ce1_allones", 64'(ce_out[1]), 64'd1);

    // Lock loss in RUN
    pll_lock = 1'b0;
    tick(2);
    checkOutput("loss_rst_pre", 64'(rst_out), 64'd0);
    checkOutput("loss_ce1_pre", 64'(ce_out[1]), 64'd1);
    checkOutput("loss_lost_pre", 64'(lost_lock_count), 64'd0);
    tick(1);
    checkOutput("loss_rst", 64'(rst_out), 64'd1);
    checkOutput("loss_locked", 64'(locked), 64'd0);
    checkOutput("loss_ce", 64'(ce_out), 64'd0);
    checkOutput("loss_lost1", 64'(lost_lock_count), 64'd1);

    // Relock: accumulator restarted from 0, so all-ones gives no carry on the first add
    pll_lock = 1'b1;
    waitLocked("relock1", 1'b1, 200);
    checkOutput("relock_ce1_first", 64'(ce_out[1]), 64'd0);
    tick(1);
    checkOutput("relock_ce1_second", 64'(ce_out[1]), 64'd1);
    pll_lock = 1'b0;
    waitLocked("drop2", 1'b0, 10);

    for (int i = 3; i <= 300; i++) begin
      pll_lock = 1'b1;
      waitLocked($sformatf("relock_%0d", i), 1'b1, 200);
      pll_lock = 1'b0;
      waitLocked($sformatf("drop_%0d", i), 1'b0, 10);
      if (i == 254) checkOutput("lost_254", 64'(lost_lock_count), 64'd254);
      if (i == 255) checkOutput("lost_255", 64'(lost_lock_count), 64'd255);
    end
    checkOutput("lost_sat_300", 64'(lost_lock_count), 64'd255);

    // Asynchronous reset mid-RUN
    pll_lock = 1'b1;
    waitLocked("relock_final", 1'b1, 200);
    tick(3);
    reset = 1'b1;
    #1;
    checkOutput("async_pll_reset", 64'(pll_reset), 64'd1);
    checkOutput("async_rst_out", 64'(rst_out), 64'd1);
    checkOutput("async_locked", 64'(locked), 64'd0);
    checkOutput("async_ce", 64'(ce_out), 64'd0);
    checkOutput("async_lost", 64'(lost_lock_count), 64'd0);

    // One-cycle lock glitch in STABLE restarts the stability count
    applyStimulus(1'b1, '0, '0);
    resetDut();
    tick(49);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(33);
    checkOutput("glitch_no_release_e83", 64'(rst_out), 64'd1);
    tick(33);
    checkOutput("glitch_rst_e116", 64'(rst_out), 64'd1);
    tick(1);
    checkOutput("glitch_rst_e117", 64'(rst_out), 64'd0);
    checkOutput("glitch_locked_e117", 64'(locked), 64'd1);

`ifdef PLL_CLK_SEQUENCER_PHASE_ALIGN_EN
    // Channels start out of phase; sync at RUN cycle 2 realigns them
    applyStimulus(1'b1, 24'(1 << 22), 24'(3 << 22));
    resetDut();
    tick(T_RELEASE);
    sync_in = 1'b1;
    tick(1);
    checkOutput("sync_ce_cleared", 64'(ce_out), 64'd0);
    sync_in = 1'b0;
    applyStimulus(1'b1, 24'(1 << 22), 24'(1 << 22));
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      checkOutput($sformatf("sync_ce0_k%0d", k), 64'(ce_out[0]), 64'((k % 4) == 0));
      checkOutput($sformatf("sync_ce1_k%0d", k), 64'(ce_out[1]), 64'((k % 4) == 0));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
